lsu_dport: RTL and testbench



---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_dport_if.sv | 31 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_dport.sv | 148 ++++++++++++++
 tb/tb_lsu_dport.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data-port initiator: funct3 encodings,
// FSM state type and small size/legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    // Byte-lane mask of an access before it is shifted to its offset.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            default:     size_mask = 4'b1111;
        endcase
    endfunction

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            default:     size_bytes = 3'd4;
        endcase
    endfunction

    // Encodings with no meaning: 011, 11x, and unsigned variants on stores.
    function automatic logic f3_illegal(input logic store, input logic [2:0] funct3);
        f3_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (store && funct3[2]);
    endfunction

endpackage

// File: rtl/lsu_dport_if.sv
// Request/response and memory data-port signals of the load/store initiator.
// The slave modport is the initiator's view; master is the CPU+memory side.
interface lsu_dport_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_data;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the data port. The write side spreads the store
// across an 8-lane (two-word) window; the read side pulls the addressed bytes
// out of a {hi,lo} word pair and extends them to 32 bits.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [3:0]  size_mask_i,
    input  logic [31:0] wdata_i,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [63:0] rd_shift;
    logic [31:0] rd_raw;

    // Write path: lanes [3:0] go to the first word, [7:4] to the next one.
    always_comb begin
        wmask_o = {4'b0000, size_mask_i} << off_i;
        wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};
    end

    // Read path: shift the pair down to the offset, then truncate and extend.
    always_comb begin
        rd_shift = {hi_i, lo_i} >> {off_i, 3'b000};
        rd_raw   = rd_shift[31:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{rd_raw[7]}}, rd_raw[7:0]};
            F3_H:    rdata_o = {{16{rd_raw[15]}}, rd_raw[15:0]};
            F3_BU:   rdata_o = {24'h0, rd_raw[7:0]};
            F3_HU:   rdata_o = {16'h0, rd_raw[15:0]};
            default: rdata_o = rd_raw;
        endcase
    end

endmodule

// File: rtl/lsu_dport.sv
// Load/store initiator for the data port of the unified word memory. Takes
// one request at a time, issues one or two word beats, and returns a single
// response pulse. Memory read data arrives registered one cycle after the
// address, so a split load latches its first word during BEAT1.
module lsu_dport
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    lsu_dport_if.slave  bus
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              err_q;
    logic              cross_q;
    logic              store_q;
    logic [1:0]        off_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;

    logic              accept;
    logic [1:0]        req_off;
    logic [2:0]        req_end;
    logic              req_cross;
    logic              req_bad;

    logic [7:0]        wmask8;
    logic [63:0]       wdata64;
    logic [31:0]       rd_hi;
    logic [31:0]       rd_lo;
    logic [31:0]       rdata;

    // Classify the incoming request: crossing and illegal encodings.
    always_comb begin
        accept    = (state_q == IDLE) && bus.req_valid;
        req_off   = bus.req_addr[1:0];
        req_end   = {1'b0, req_off} + size_bytes(bus.req_funct3);
        req_cross = (req_end > 3'd4);
        req_bad   = f3_illegal(bus.req_store, bus.req_funct3) || (req_cross && !SPLIT_EN);
    end

    // Next-state and memory address sequencing.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_d = DONE;
                    end else begin
                        state_d    = BEAT0;
                        mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            BEAT0: begin
                if (cross_q) begin
                    state_d    = BEAT1;
                    mem_addr_d = mem_addr_q + ADDR_W'(4);
                end else begin
                    state_d = DONE;
                end
            end
            BEAT1:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, held memory address and per-request flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
            cross_q    <= 1'b0;
            store_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            if (accept) begin
                err_q   <= req_bad;
                cross_q <= req_cross;
                store_q <= bus.req_store;
            end
        end
    end

    // Request payload and the first word of a split load; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            off_q   <= req_off;
            f3_q    <= bus.req_funct3;
            wdata_q <= bus.req_wdata;
        end
        if (state_q == BEAT1) begin
            lo_q <= bus.mem_data;
        end
    end

    // In DONE, mem_data holds the last beat's word: lo if single, hi if split.
    always_comb begin
        rd_hi = cross_q ? bus.mem_data : 32'h0;
        rd_lo = cross_q ? lo_q : bus.mem_data;
    end

    lsu_lane_align u_align (
        .off_i       (off_q),
        .size_mask_i (size_mask(f3_q)),
        .wdata_i     (wdata_q),
        .wmask_o     (wmask8),
        .wdata_o     (wdata64),
        .hi_i        (rd_hi),
        .lo_i        (rd_lo),
        .funct3_i    (f3_q),
        .rdata_o     (rdata)
    );

    // Outputs decoded from the state register, so write enables drop as soon
    // as reset is applied.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_err   = (state_q == DONE) && err_q;
        bus.rsp_data  = ((state_q == DONE) && !err_q && !store_q) ? rdata : 32'h0;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wmask = 4'b0000;
        bus.mem_wdata = 32'h0;
        case (state_q)
            BEAT0: begin
                bus.mem_wmask = store_q ? wmask8[3:0] : 4'b0000;
                bus.mem_wdata = wdata64[31:0];
            end
            BEAT1: begin
                bus.mem_wmask = store_q ? wmask8[7:4] : 4'b0000;
                bus.mem_wdata = wdata64[63:32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_dport.sv
// Directed bench for lsu_dport: a split-enabled instance backed by a
// registered-read word memory, plus a SPLIT_EN=0 instance for the error path.
module tb_lsu_dport;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_dport_if #(.ADDR_W(32)) bus ();
    lsu_dport_if #(.ADDR_W(32)) bus_ns ();

    lsu_dport #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    lsu_dport #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_ns (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_ns.slave)
    );

    // Word memory: byte writes from the DUT, preload port for the bench,
    // read data registered one cycle after the address.
    logic [31:0] mem [0:16383];
    logic        pl_en;
    logic [13:0] pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) mem[bus.mem_addr[15:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        bus.mem_data <= mem[bus.mem_addr[15:2]];
    end
    assign bus_ns.mem_data = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [31:0] o_addr  [0:5];
    logic [3:0]  o_mask  [0:5];
    logic [31:0] o_wdata [0:5];
    logic        o_rv    [0:5];
    logic [31:0] o_rd    [0:5];
    logic        o_err   [0:5];
    logic        o_rdy   [0:5];
    int          rsp_at;
    int          rsp_cnt;
    logic [3:0]  any_mask;

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = a[15:2];
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Issue one request, then record five cycles of DUT outputs (index = cycles after accept).
    task automatic do_req(input bit ns, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        if (ns) begin
            bus_ns.req_valid = 1'b1; bus_ns.req_store = st; bus_ns.req_funct3 = f3;
            bus_ns.req_addr  = a;    bus_ns.req_wdata = wd;
            o_rdy[0] = bus_ns.req_ready;
        end else begin
            bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
            bus.req_addr  = a;    bus.req_wdata = wd;
            o_rdy[0] = bus.req_ready;
        end
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus_ns.req_valid = 1'b0;
        o_rv[0] = 1'b0; o_rd[0] = 32'h0; o_err[0] = 1'b0;
        rsp_at = 0; rsp_cnt = 0; any_mask = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ns) begin
                o_addr[k] = bus_ns.mem_addr;  o_mask[k] = bus_ns.mem_wmask; o_wdata[k] = bus_ns.mem_wdata;
                o_rv[k]   = bus_ns.rsp_valid; o_rd[k]   = bus_ns.rsp_data;  o_err[k]   = bus_ns.rsp_err;
                o_rdy[k]  = bus_ns.req_ready;
            end else begin
                o_addr[k] = bus.mem_addr;  o_mask[k] = bus.mem_wmask; o_wdata[k] = bus.mem_wdata;
                o_rv[k]   = bus.rsp_valid; o_rd[k]   = bus.rsp_data;  o_err[k]   = bus.rsp_err;
                o_rdy[k]  = bus.req_ready;
            end
            any_mask = any_mask | o_mask[k];
            if (o_rv[k]) begin
                rsp_cnt++;
                if (rsp_at == 0) rsp_at = k;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus.rsp_err); end
        checks++; if (bus.mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_wmask: got %b want 0000", bus.mem_wmask); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_load_word();
        poke(32'h100, 32'hDEADBEEF);
        poke(32'h104, 32'hCAFEF00D);
        do_req(0, 1'b0, F3_W, 32'h100, 32'h0);
        checks++; if (o_rdy[0] !== 1'b1) begin errors++; $display("FAIL lw_ready_idle: got %b want 1", o_rdy[0]); end
        checks++; if (o_rdy[1] !== 1'b0) begin errors++; $display("FAIL lw_ready_busy: got %b want 0", o_rdy[1]); end
        checks++; if (o_addr[1] !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h want 00000100", o_addr[1]); end
        checks++; if (any_mask !== 4'h0) begin errors++; $display("FAIL lw_wmask: got %b want 0000", any_mask); end
        checks++; if (rsp_at !== 2 || rsp_cnt !== 1) begin errors++; $display("FAIL lw_latency: got at=%0d cnt=%0d want at=2 cnt=1", rsp_at, rsp_cnt); end
        checks++; if (o_rd[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", o_rd[2]); end
        checks++; if (o_err[2] !== 1'b0) begin errors++; $display("FAIL lw_err: got %b want 0", o_err[2]); end
    endtask

    task automatic test_load_subword();
        do_req(0, 1'b0, F3_B, 32'h103, 32'h0);
        checks++; if (o_rd[2] !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_103: got %h want ffffffde", o_rd[2]); end
        do_req(0, 1'b0, F3_BU, 32'h103, 32'h0);
        checks++; if (o_rd[2] !== 32'h000000DE) begin errors++; $display("FAIL lbu_103: got %h want 000000de", o_rd[2]); end
        do_req(0, 1'b0, F3_H, 32'h102, 32'h0);
        checks++; if (o_rd[2] !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_102: got %h want ffffdead", o_rd[2]); end
        do_req(0, 1'b0, F3_HU, 32'h100, 32'h0);
        checks++; if (o_rd[2] !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_100: got %h want 0000beef", o_rd[2]); end
    endtask

    task automatic test_store_half();
        do_req(0, 1'b1, F3_H, 32'h102, 32'h00001234);
        checks++; if (o_addr[1] !== 32'h100) begin errors++; $display("FAIL sh_addr: got %h want 00000100", o_addr[1]); end
        checks++; if (o_mask[1] !== 4'b1100) begin errors++; $display("FAIL sh_wmask: got %b want 1100", o_mask[1]); end
        checks++; if (o_wdata[1][31:16] !== 16'h1234) begin errors++; $display("FAIL sh_wdata: got %h want 1234", o_wdata[1][31:16]); end
        checks++; if (rsp_at !== 2 || o_rd[2] !== 32'h0) begin errors++; $display("FAIL sh_rsp: got at=%0d data=%h want at=2 data=0", rsp_at, o_rd[2]); end
        checks++; if (o_mask[2] !== 4'h0) begin errors++; $display("FAIL sh_done_wmask: got %b want 0000", o_mask[2]); end
        do_req(0, 1'b0, F3_W, 32'h100, 32'h0);
        checks++; if (o_rd[2] !== 32'h1234BEEF) begin errors++; $display("FAIL sh_readback: got %h want 1234beef", o_rd[2]); end
    endtask

    task automatic test_split_load();
        poke(32'h0FC, 32'hAABBCCDD);
        poke(32'h100, 32'h11223344);
        do_req(0, 1'b0, F3_W, 32'h0FE, 32'h0);
        checks++; if (o_addr[1] !== 32'h0FC) begin errors++; $display("FAIL slw_beat0_addr: got %h want 000000fc", o_addr[1]); end
        checks++; if (o_addr[2] !== 32'h100) begin errors++; $display("FAIL slw_beat1_addr: got %h want 00000100", o_addr[2]); end
        checks++; if (any_mask !== 4'h0) begin errors++; $display("FAIL slw_wmask: got %b want 0000", any_mask); end
        checks++; if (rsp_at !== 3 || rsp_cnt !== 1) begin errors++; $display("FAIL slw_latency: got at=%0d cnt=%0d want at=3 cnt=1", rsp_at, rsp_cnt); end
        checks++; if (o_rd[3] !== 32'h3344AABB) begin errors++; $display("FAIL slw_data: got %h want 3344aabb", o_rd[3]); end
        do_req(0, 1'b0, F3_H, 32'h0FF, 32'h0);
        checks++; if (rsp_at !== 3 || o_rd[3] !== 32'h000044AA) begin errors++; $display("FAIL slh_0ff: got at=%0d data=%h want at=3 data=000044aa", rsp_at, o_rd[3]); end
    endtask

    task automatic test_split_store_reset();
        logic [3:0] m;
        logic       seen;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_W;
        bus.req_addr  = 32'h103; bus.req_wdata = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h100 || bus.mem_wmask !== 4'b1000) begin errors++; $display("FAIL ssw_beat0: got addr=%h mask=%b want 00000100/1000", bus.mem_addr, bus.mem_wmask); end
        checks++; if (bus.mem_wdata[31:24] !== 8'h44) begin errors++; $display("FAIL ssw_beat0_data: got %h want 44", bus.mem_wdata[31:24]); end
        @(negedge clk);
        checks++; if (bus.mem_addr !== 32'h104 || bus.mem_wmask !== 4'b0111) begin errors++; $display("FAIL ssw_beat1: got addr=%h mask=%b want 00000104/0111", bus.mem_addr, bus.mem_wmask); end
        checks++; if (bus.mem_wdata[23:0] !== 24'h112233) begin errors++; $display("FAIL ssw_beat1_data: got %h want 112233", bus.mem_wdata[23:0]); end
        #2 reset = 1'b1;
        #1 m = bus.mem_wmask;
        checks++; if (m !== 4'h0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL ssw_reset_now: got mask=%b ready=%b want 0000/1", m, bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ssw_no_rsp: got %b want 0", seen); end
        do_req(0, 1'b0, F3_W, 32'h100, 32'h0);
        checks++; if (o_rd[2] !== 32'h44223344) begin errors++; $display("FAIL ssw_low_kept: got %h want 44223344", o_rd[2]); end
        do_req(0, 1'b0, F3_W, 32'h104, 32'h0);
        checks++; if (o_rd[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL ssw_high_untouched: got %h want cafef00d", o_rd[2]); end
    endtask

    task automatic test_error();
        do_req(0, 1'b0, 3'b011, 32'h100, 32'h0);
        checks++; if (rsp_at !== 1 || rsp_cnt !== 1) begin errors++; $display("FAIL err_latency: got at=%0d cnt=%0d want at=1 cnt=1", rsp_at, rsp_cnt); end
        checks++; if (o_err[1] !== 1'b1 || o_rd[1] !== 32'h0) begin errors++; $display("FAIL err_rsp: got err=%b data=%h want 1/0", o_err[1], o_rd[1]); end
        checks++; if (any_mask !== 4'h0) begin errors++; $display("FAIL err_wmask: got %b want 0000", any_mask); end
        do_req(0, 1'b1, F3_BU, 32'h100, 32'hFFFFFFFF);
        checks++; if (rsp_at !== 1 || o_err[1] !== 1'b1 || any_mask !== 4'h0) begin errors++; $display("FAIL err_store_bu: got at=%0d err=%b mask=%b want 1/1/0000", rsp_at, o_err[1], any_mask); end
        do_req(0, 1'b0, 3'b110, 32'h100, 32'h0);
        checks++; if (rsp_at !== 1 || o_err[1] !== 1'b1) begin errors++; $display("FAIL err_110: got at=%0d err=%b want 1/1", rsp_at, o_err[1]); end
        do_req(0, 1'b0, F3_W, 32'h100, 32'h0);
        checks++; if (o_rd[2] !== 32'h44223344 || o_err[2] !== 1'b0) begin errors++; $display("FAIL err_mem_intact: got %h err=%b want 44223344/0", o_rd[2], o_err[2]); end
    endtask

    task automatic test_nosplit();
        do_req(1, 1'b0, F3_H, 32'h0FF, 32'h0);
        checks++; if (rsp_at !== 1 || o_err[1] !== 1'b1 || o_rd[1] !== 32'h0) begin errors++; $display("FAIL ns_cross: got at=%0d err=%b data=%h want 1/1/0", rsp_at, o_err[1], o_rd[1]); end
        checks++; if (any_mask !== 4'h0) begin errors++; $display("FAIL ns_wmask: got %b want 0000", any_mask); end
        do_req(1, 1'b0, F3_H, 32'h0FE, 32'h0);
        checks++; if (rsp_at !== 2 || o_err[2] !== 1'b0 || o_addr[1] !== 32'h0FC) begin errors++; $display("FAIL ns_aligned: got at=%0d err=%b addr=%h want 2/0/000000fc", rsp_at, o_err[2], o_addr[1]); end
    endtask

    initial begin
        reset = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        bus.req_valid    = 1'b0; bus.req_store    = 1'b0; bus.req_funct3    = 3'b000;
        bus.req_addr     = '0;   bus.req_wdata    = '0;
        bus_ns.req_valid = 1'b0; bus_ns.req_store = 1'b0; bus_ns.req_funct3 = 3'b000;
        bus_ns.req_addr  = '0;   bus_ns.req_wdata = '0;
        #1 reset = 1'b1;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store_half();
        test_split_load();
        test_split_store_reset();
        test_error();
        test_nosplit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
